// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S transmit path.
package audio_pkg;

    localparam int DATA_W        = 16;
    localparam int SLOT_BITS_DEF = 32;

    typedef logic [DATA_W-1:0] sample_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock generator: divides clk down to BCLK and flags the cycle in which
// BCLK is about to rise or fall, so callers can register alongside the toggle.
module i2s_clk_div #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          tc;

    assign tc   = (div_cnt == CW'(BCLK_DIV - 1));
    assign rise = tc & ~bclk;
    assign fall = tc & bclk;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: one-entry sample buffer, frame loader and bit shifter.
// The same sample goes out in the left and right slot of each frame.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic    clk,
    input  logic    reset_n,
    input  sample_t sample_in,
    input  logic    sample_valid,
    output logic    sample_ready,
    output logic    i2s_bclk,
    output logic    i2s_lrclk,
    output logic    i2s_sdata,
    output logic    frame_start,
    output logic    underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BW         = $clog2(FRAME_BITS);

    logic          fall;
    logic          rise_unused;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_cnt_nxt;
    logic [BW-1:0] slot_pos;
    logic          load;
    logic          sdata_nxt;
    sample_t       frame_sample;
    sample_t       buf_q;
    logic          buf_full;

    i2s_clk_div #(
        .BCLK_DIV(BCLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .reset_n(reset_n),
        .bclk   (i2s_bclk),
        .rise   (rise_unused),
        .fall   (fall)
    );

    assign sample_ready = ~buf_full;
    assign bit_cnt_nxt  = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    assign load         = fall && (bit_cnt_nxt == '0);
    assign slot_pos     = (bit_cnt_nxt >= BW'(SLOT_BITS)) ? bit_cnt_nxt - BW'(SLOT_BITS)
                                                           : bit_cnt_nxt;

    // Slot position 1 carries the MSB (one-BCLK I2S delay); past DATA_W it pads with zeros.
    always_comb begin
        sdata_nxt = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (slot_pos == BW'(DATA_W - i)) sdata_nxt = frame_sample[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt      <= '0;
            i2s_lrclk    <= LR_LEFT;
            i2s_sdata    <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            frame_sample <= '0;
            buf_q        <= '0;
            buf_full     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (fall) begin
                bit_cnt   <= bit_cnt_nxt;
                i2s_lrclk <= (bit_cnt_nxt >= BW'(SLOT_BITS)) ? LR_RIGHT : LR_LEFT;
                i2s_sdata <= sdata_nxt;
            end
            // An empty buffer with a sample arriving on the load cycle bypasses straight in.
            if (load) begin
                frame_start <= 1'b1;
                if (buf_full) begin
                    frame_sample <= buf_q;
                    buf_full     <= 1'b0;
                end else if (sample_valid) begin
                    frame_sample <= sample_in;
                end else begin
                    underrun <= 1'b1;
                end
            end else if (sample_valid && !buf_full) begin
                buf_q    <= sample_in;
                buf_full <= 1'b1;
            end
        end
    end

endmodule
